cache_axi_ctrl: RTL and testbench

CACHE_AXI_CTRL -- requirements
Module: cache_axi_ctrl

---
 rtl/cache_axi_ctrl_if.sv | 34 +++
 rtl/cache_axi_ctrl.sv | 112 +++++++++++
 tb/tb_cache_axi_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cache_axi_ctrl_if.sv
// AXI burst channels between the cache line controller and memory.
// master = cache controller, slave = memory/interconnect.
interface cache_axi_ctrl_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic        rlast;
    logic        awvalid;
    logic        awready;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic        wvalid;
    logic        wready;
    logic [31:0] wdata;
    logic        wlast;
    logic        bvalid;
    logic        bready;

    modport master (
        output arvalid, araddr, arlen, rready,
        output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        input  arready, rvalid, rdata, rlast, awready, wready, bvalid
    );

    modport slave (
        input  arvalid, araddr, arlen, rready,
        input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
        output arready, rvalid, rdata, rlast, awready, wready, bvalid
    );
endinterface

// File: rtl/cache_axi_ctrl.sv
// Cache miss handler: optional victim write-back burst, then a refill read burst,
// finishing with a one-cycle refresh pulse for the tag/data/LRU update.
module cache_axi_ctrl #(
    parameter int BEATS  = 8,
    parameter int LINE_W = BEATS * 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              miss,
    input  logic              write_back,
    input  logic [31:0]       axi_raddr,
    input  logic [31:0]       axi_waddr,
    input  logic [LINE_W-1:0] evict_data,
    output logic [LINE_W-1:0] refill_data,
    output logic              refresh,
    cache_axi_ctrl_if.master  axi
);
    localparam int             CW   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]  LAST = CW'(BEATS - 1);
    localparam logic [7:0]     ALEN = 8'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, AW, W, B, AR, R, DONE} state_t;

    state_t                 state, state_n;
    logic [CW-1:0]          cnt;
    logic [31:0]            raddr_q, waddr_q;
    logic [BEATS-1:0][31:0] evict_q;
    logic [BEATS-1:0][31:0] refill_q;

    assign refill_data = refill_q;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Every output is decoded from registered state only, so no ready->valid path exists.
    always_comb begin
        state_n     = state;
        refresh     = 1'b0;
        axi.awvalid = 1'b0;
        axi.awaddr  = '0;
        axi.awlen   = ALEN;
        axi.wvalid  = 1'b0;
        axi.wdata   = '0;
        axi.wlast   = 1'b0;
        axi.bready  = 1'b0;
        axi.arvalid = 1'b0;
        axi.araddr  = '0;
        axi.arlen   = ALEN;
        axi.rready  = 1'b0;
        case (state)
            IDLE: if (miss) state_n = write_back ? AW : AR;
            AW: begin
                axi.awvalid = 1'b1;
                axi.awaddr  = waddr_q;
                if (axi.awready) state_n = W;
            end
            W: begin
                axi.wvalid = 1'b1;
                axi.wdata  = evict_q[cnt];
                axi.wlast  = (cnt == LAST);
                if (axi.wready && cnt == LAST) state_n = B;
            end
            B: begin
                axi.bready = 1'b1;
                if (axi.bvalid) state_n = AR;
            end
            AR: begin
                axi.arvalid = 1'b1;
                axi.araddr  = raddr_q;
                if (axi.arready) state_n = R;
            end
            R: begin
                axi.rready = 1'b1;
                if (axi.rvalid && axi.rlast) state_n = DONE;
            end
            DONE: begin
                refresh = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request fields are captured once on leaving IDLE; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            raddr_q  <= '0;
            waddr_q  <= '0;
            evict_q  <= '0;
            refill_q <= '0;
        end else begin
            case (state)
                IDLE: if (miss) begin
                    raddr_q <= axi_raddr;
                    waddr_q <= axi_waddr;
                    evict_q <= evict_data;
                end
                AW: if (axi.awready) cnt <= '0;
                W:  if (axi.wready)  cnt <= cnt + 1'b1;
                AR: if (axi.arready) cnt <= '0;
                R:  if (axi.rvalid) begin
                    refill_q[cnt] <= axi.rdata;
                    cnt           <= cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_axi_ctrl.sv
// Scoreboard bench for cache_axi_ctrl: directed misses push expectations, a monitor
// pops and compares on every AW/W/AR handshake and every refresh pulse.
module tb_cache_axi_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, miss, write_back, refresh;
    logic [31:0]  axi_raddr, axi_waddr;
    logic [255:0] evict_data, refill_data;

    cache_axi_ctrl_if axi();

    cache_axi_ctrl #(.BEATS(8), .LINE_W(256)) dut (
        .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
        .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .evict_data(evict_data),
        .refill_data(refill_data), .refresh(refresh), .axi(axi)
    );

    int checks = 0, failures = 0, cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0]  exp_aw[$];
    logic [32:0]  exp_w[$];
    logic [31:0]  exp_ar[$];
    logic [255:0] exp_line[$];
    int           exp_cyc[$];
    logic [255:0] model_line = '0;

    bit          bp = 0, b_pending = 0;
    int          bdelay = 0, b_wait = 0, r_left = 0, rbeat = 0, r_last_idx = 7;
    logic [31:0] rmem[8];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        failures++;
        $display("FAIL %s act=event exp=none", nm);
    endtask

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    // Memory model: drives slave inputs on every falling edge.
    initial begin
        axi.awready = 1'b0; axi.wready = 1'b0; axi.arready = 1'b0;
        axi.bvalid = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rlast = 1'b0;
        forever begin
            @(negedge clk);
            axi.awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            axi.arready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            if (b_pending && b_wait > 0) b_wait--;
            axi.bvalid = b_pending && (b_wait == 0);
            axi.rvalid = (r_left > 0) && (bp ? 1'($urandom_range(0, 1)) : 1'b1);
            axi.rdata  = rmem[rbeat[2:0]];
            axi.rlast  = (rbeat == r_last_idx);
        end
    end

    // Monitor: protocol holds plus scoreboard pops.
    initial begin
        logic        p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_ref = 0, p_wl = 0;
        logic [31:0] p_awa = 0, p_wd = 0, p_ara = 0;
        logic [32:0] ew;
        int          ec;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                p_awv = 0; p_wv = 0; p_arv = 0; p_ref = 0;
            end else begin
                if (p_awv && !p_awr) chk("aw_hold", 256'({axi.awvalid, axi.awaddr}), 256'({1'b1, p_awa}));
                if (p_wv && !p_wr)   chk("w_hold", 256'({axi.wvalid, axi.wlast, axi.wdata}), 256'({1'b1, p_wl, p_wd}));
                if (p_arv && !p_arr) chk("ar_hold", 256'({axi.arvalid, axi.araddr}), 256'({1'b1, p_ara}));
                if (b_pending) chk("b_state_ar_bready", 256'({axi.arvalid, axi.bready}), 256'(2'b01));
                if (axi.awvalid && axi.awready) begin
                    if (exp_aw.size() == 0) fail_now("aw_unexpected");
                    else chk("aw_addr_len", 256'({axi.awaddr, axi.awlen}), 256'({exp_aw.pop_front(), 8'd7}));
                end
                if (axi.wvalid && axi.wready) begin
                    if (exp_w.size() == 0) fail_now("w_unexpected");
                    else begin
                        ew = exp_w.pop_front();
                        chk("w_beat", 256'({axi.wlast, axi.wdata}), 256'(ew));
                    end
                    if (axi.wlast) begin b_pending = 1; b_wait = bdelay; end
                end
                if (axi.bvalid && axi.bready) b_pending = 0;
                if (axi.arvalid && axi.arready) begin
                    if (exp_ar.size() == 0) fail_now("ar_unexpected");
                    else chk("ar_addr_len", 256'({axi.araddr, axi.arlen}), 256'({exp_ar.pop_front(), 8'd7}));
                    r_left = r_last_idx + 1;
                    rbeat  = 0;
                end
                if (axi.rvalid && axi.rready) begin rbeat++; r_left--; end
                if (refresh) begin
                    if (p_ref) fail_now("refresh_double");
                    if (exp_line.size() == 0) fail_now("refresh_unexpected");
                    else begin
                        chk("refill_line", refill_data, exp_line.pop_front());
                        ec = exp_cyc.pop_front();
                        if (ec >= 0) chk("refresh_cycle", 256'(cyc), 256'(ec));
                    end
                end
                p_awv = axi.awvalid; p_awr = axi.awready; p_awa = axi.awaddr;
                p_wv  = axi.wvalid;  p_wr  = axi.wready;  p_wd  = axi.wdata; p_wl = axi.wlast;
                p_arv = axi.arvalid; p_arr = axi.arready; p_ara = axi.araddr;
                p_ref = refresh;
            end
        end
    end

    task automatic run_miss(input bit wb, input logic [31:0] ra, input logic [31:0] wa,
                            input logic [31:0] ebase, input logic [31:0] rbase,
                            input int last, input int lat, input bit hold);
        logic [255:0] ev;
        bit seen;
        for (int k = 0; k < 8; k++) begin
            ev[32*k +: 32] = ebase + 32'(k);
            rmem[k] = rbase + 32'(k);
        end
        if (wb) begin
            exp_aw.push_back(wa);
            for (int k = 0; k < 8; k++) exp_w.push_back({k == 7, ebase + 32'(k)});
        end
        exp_ar.push_back(ra);
        for (int k = 0; k <= last; k++) model_line[32*k +: 32] = rbase + 32'(k);
        exp_line.push_back(model_line);
        r_last_idx = last;
        step();
        axi_raddr = ra; axi_waddr = wa; evict_data = ev; write_back = wb; miss = 1'b1;
        exp_cyc.push_back(lat < 0 ? -1 : cyc + lat);
        step();
        axi_raddr = ~ra; axi_waddr = ~wa; evict_data = ~ev; write_back = ~wb;
        seen = 0;
        for (int i = 0; i < 400 && !seen; i++) begin
            if (refresh) seen = 1;
            else step();
        end
        if (!seen) fail_now("refresh_timeout");
        if (hold) begin
            step();
            miss = 1'b0;
            for (int i = 0; i < 12; i++) begin
                step();
                chk("no_reentry", 256'({axi.arvalid, axi.awvalid, refresh}), '0);
            end
        end else miss = 1'b0;
        step();
    endtask

    initial begin
        logic [255:0] ev;
        bit found;
        rst = 1'b1; miss = 1'b0; write_back = 1'b0;
        axi_raddr = '0; axi_waddr = '0; evict_data = '0;
        step(); step();
        chk("rst_valids", 256'({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready, axi.bready}), '0);
        chk("rst_refresh", 256'(refresh), '0);
        chk("rst_bus", 256'({axi.awaddr, axi.araddr, axi.wdata, axi.wlast}), '0);
        chk("rst_lens", 256'({axi.awlen, axi.arlen}), 256'(16'h0707));
        chk("rst_refill", refill_data, '0);
        rst = 1'b0;
        step();

        run_miss(0, 32'h1FC0_0020, 32'h0, 32'h0, 32'h1, 7, 10, 0);
        run_miss(1, 32'h0000_2000, 32'h0000_1000, 32'hA0, 32'h100, 7, 20, 0);
        bp = 1; bdelay = 5;
        run_miss(1, 32'h0000_4000, 32'h0000_3000, 32'hC0, 32'h200, 7, -1, 0);
        bp = 0; bdelay = 0;
        run_miss(0, 32'h0000_5000, 32'h0, 32'h0, 32'h300, 4, -1, 0);
        run_miss(0, 32'h0000_6000, 32'h0, 32'h0, 32'h400, 7, 10, 1);

        // Reset in the middle of the write burst, then a normal refill.
        exp_aw.push_back(32'h7000);
        for (int k = 0; k < 8; k++) begin
            ev[32*k +: 32] = 32'hB0 + 32'(k);
            exp_w.push_back({k == 7, 32'hB0 + 32'(k)});
        end
        step();
        axi_waddr = 32'h7000; axi_raddr = 32'h7800; evict_data = ev; write_back = 1'b1; miss = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (axi.wvalid && axi.wdata == 32'hB3) found = 1;
            else step();
        end
        chk("w_beat3_reached", 256'(found), 256'(1));
        rst = 1'b1; miss = 1'b0;
        exp_aw.delete(); exp_w.delete(); exp_ar.delete(); exp_line.delete(); exp_cyc.delete();
        b_pending = 0; r_left = 0; model_line = '0;
        step();
        chk("rst_mid_valids", 256'({axi.awvalid, axi.wvalid, axi.arvalid, axi.rready, axi.bready, refresh}), '0);
        chk("rst_mid_bus", 256'({axi.awaddr, axi.wdata, axi.wlast, axi.araddr}), '0);
        chk("rst_mid_refill", refill_data, '0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_mid_idle", 256'({axi.awvalid, axi.wvalid, axi.arvalid, refresh}), '0);
        end
        run_miss(0, 32'h0000_8000, 32'h0, 32'h0, 32'h500, 7, 10, 0);

        for (int i = 0; i < 5; i++) step();
        chk("queues_drained", 256'(exp_aw.size() + exp_w.size() + exp_ar.size() + exp_line.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
